// File: rtl/wlm_red_pipe_if.sv
// Handshake/data bundle for wlm_red_pipe: operand side (in_*) and result side (out_*).
interface wlm_red_pipe_if #(
  parameter int LOGQH = 17,
  parameter int W     = 43,
  parameter int TAGW  = 8
);
  localparam int LOGQ = LOGQH + W;

  logic                in_valid;
  logic                in_ready;
  logic [LOGQH-1:0]    qH;
  logic [2*LOGQ-1:0]   C;
  logic [TAGW-1:0]     in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [LOGQ:0]       T;
  logic [TAGW-1:0]     out_tag;

  modport master (
    output in_valid, qH, C, in_tag, out_ready,
    input  in_ready, out_valid, T, out_tag
  );

  modport slave (
    input  in_valid, qH, C, in_tag, out_ready,
    output in_ready, out_valid, T, out_tag
  );
endinterface

// File: rtl/wlm_red_pipe.sv
// Pipelined word-level Montgomery reduction: T == C*2^(-NSTAGE*W) mod q, q = qH*2^W + 1.
// Define WLM_RED_PIPE_CORRECT_EN to add a final register stage that subtracts q when T >= q.
module wlm_red_pipe #(
  parameter int LOGQH  = 17,
  parameter int W      = 43,
  parameter int NSTAGE = 2,
  parameter int FF_MUL = 1,
  parameter int TAGW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  wlm_red_pipe_if.slave io
);
  localparam int LOGQ = LOGQH + W;
  localparam int DW   = 2*LOGQ + 1;
  localparam int MW   = LOGQH + W;
  localparam int RW   = LOGQ + 1;

  if (W < 2) begin : g_chk_w
    $error("wlm_red_pipe: W must be >= 2");
  end
  if (NSTAGE*W < LOGQ+1) begin : g_chk_n
    $error("wlm_red_pipe: NSTAGE*W must be >= LOGQ+1");
  end

  logic en;
  logic out_valid;

  // x_q[i] is the operand entering stage i; x_q[0] is the input register
  logic [DW-1:0]     x_q    [NSTAGE];
  logic [DW-1:0]     x_d    [NSTAGE];
  logic [LOGQH-1:0]  qh_q   [NSTAGE];
  logic [LOGQH-1:0]  qh_d   [NSTAGE];
  logic [TAGW-1:0]   tag_q  [NSTAGE];
  logic [TAGW-1:0]   tag_d  [NSTAGE];
  logic [NSTAGE-1:0] v_q, v_d;

  logic [W-1:0]      cl_c   [NSTAGE];
  logic [W-1:0]      m_c    [NSTAGE];

  logic [DW-1:0]     hi_q   [NSTAGE];
  logic [DW-1:0]     hi_d   [NSTAGE];
  logic [MW-1:0]     mul_q  [NSTAGE];
  logic [MW-1:0]     mul_d  [NSTAGE];
  logic [LOGQH-1:0]  pqh_q  [NSTAGE];
  logic [LOGQH-1:0]  pqh_d  [NSTAGE];
  logic [TAGW-1:0]   ptag_q [NSTAGE];
  logic [TAGW-1:0]   ptag_d [NSTAGE];
  logic [NSTAGE-1:0] pv_q, pv_d;

  logic [DW-1:0]     s_sum  [NSTAGE];
  logic [LOGQH-1:0]  s_qh   [NSTAGE];
  logic [TAGW-1:0]   s_tag  [NSTAGE];
  logic [NSTAGE-1:0] s_v;

  logic [RW-1:0]     xn_q, xn_d;
  logic [TAGW-1:0]   tagn_q, tagn_d;
  logic              vn_q, vn_d;
`ifdef WLM_RED_PIPE_CORRECT_EN
  logic [LOGQH-1:0]  qhn_q, qhn_d;
`endif

  assign en          = ~out_valid | io.out_ready;
  assign io.in_ready = en;

  always_comb begin
    x_d[0]   = DW'(io.C);
    qh_d[0]  = io.qH;
    tag_d[0] = io.in_tag;
    v_d[0]   = io.in_valid;

    // X' = (X >> W) + (Cl != 0) + qH*m, i.e. (X + m*q) / 2^W exactly
    for (int i = 0; i < NSTAGE; i++) begin
      cl_c[i]   = x_q[i][W-1:0];
      m_c[i]    = W'(0) - cl_c[i];
      hi_d[i]   = (x_q[i] >> W) + DW'(cl_c[i] != '0);
      mul_d[i]  = MW'(qh_q[i]) * MW'(m_c[i]);
      pqh_d[i]  = qh_q[i];
      ptag_d[i] = tag_q[i];
      pv_d[i]   = v_q[i];
      if (FF_MUL != 0) begin
        s_sum[i] = hi_q[i] + DW'(mul_q[i]);
        s_qh[i]  = pqh_q[i];
        s_tag[i] = ptag_q[i];
        s_v[i]   = pv_q[i];
      end else begin
        s_sum[i] = hi_d[i] + DW'(mul_d[i]);
        s_qh[i]  = qh_q[i];
        s_tag[i] = tag_q[i];
        s_v[i]   = v_q[i];
      end
    end

    for (int i = 1; i < NSTAGE; i++) begin
      x_d[i]   = s_sum[i-1];
      qh_d[i]  = s_qh[i-1];
      tag_d[i] = s_tag[i-1];
      v_d[i]   = s_v[i-1];
    end

    // last-stage value is below 2q, so LOGQ+1 bits hold it
    xn_d   = RW'(s_sum[NSTAGE-1]);
    tagn_d = s_tag[NSTAGE-1];
    vn_d   = s_v[NSTAGE-1];
`ifdef WLM_RED_PIPE_CORRECT_EN
    qhn_d  = s_qh[NSTAGE-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      pv_q <= '0;
      vn_q <= 1'b0;
    end else if (en) begin
      v_q  <= v_d;
      pv_q <= pv_d;
      vn_q <= vn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x_q    <= x_d;
      qh_q   <= qh_d;
      tag_q  <= tag_d;
      hi_q   <= hi_d;
      mul_q  <= mul_d;
      pqh_q  <= pqh_d;
      ptag_q <= ptag_d;
      xn_q   <= xn_d;
      tagn_q <= tagn_d;
`ifdef WLM_RED_PIPE_CORRECT_EN
      qhn_q  <= qhn_d;
`endif
    end
  end

`ifdef WLM_RED_PIPE_CORRECT_EN
  logic [RW-1:0]   q_full;
  logic [RW-1:0]   c_q, c_d;
  logic [TAGW-1:0] ctag_q, ctag_d;
  logic            cv_q, cv_d;

  always_comb begin
    q_full = {1'b0, qhn_q, {W{1'b0}}} + RW'(1);
    c_d    = (xn_q >= q_full) ? (xn_q - q_full) : xn_q;
    ctag_d = tagn_q;
    cv_d   = vn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q <= 1'b0;
    end else if (en) begin
      cv_q <= cv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      c_q    <= c_d;
      ctag_q <= ctag_d;
    end
  end

  assign out_valid  = cv_q;
  assign io.T       = c_q;
  assign io.out_tag = ctag_q;
`else
  assign out_valid  = vn_q;
  assign io.T       = xn_q;
  assign io.out_tag = tagn_q;
`endif

  assign io.out_valid = out_valid;
endmodule

// File: tb/tb_wlm_red_pipe.sv
// Directed bench for wlm_red_pipe with LOGQH=4, W=4, NSTAGE=3 (q = 193 or 49); adapts to WLM_RED_PIPE_CORRECT_EN.
module tb_wlm_red_pipe;
  localparam int LOGQH  = 4;
  localparam int W      = 4;
  localparam int NSTAGE = 3;
  localparam int FF_MUL = 1;
  localparam int TAGW   = 8;
`ifdef WLM_RED_PIPE_CORRECT_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif
  localparam int LAT = 1 + NSTAGE*(1+FF_MUL) + (CORR ? 1 : 0);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  wlm_red_pipe_if #(.LOGQH(LOGQH), .W(W), .TAGW(TAGW)) io ();

  wlm_red_pipe #(
    .LOGQH(LOGQH), .W(W), .NSTAGE(NSTAGE), .FF_MUL(FF_MUL), .TAGW(TAGW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // r in [0,q) with r*2^12 == c (mod q)
  function automatic int mont_ref(input int c, input int q);
    for (int r = 0; r < q; r++) begin
      if ((r*4096) % q == c % q) return r;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b1; io.C = '0; io.qH = 4'd12; io.in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (io.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
    n_cmp++;
    if (io.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready); end
  endtask

  task automatic test_single(input logic [15:0] c, input logic [3:0] qh, input logic [7:0] tag,
                             input int exp_t, input string name);
    int cyc;
    int q;
    int t;
    q = int'(qh)*16 + 1;
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.C = c; io.qH = qh; io.in_tag = tag; io.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (io.in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b want 1", name, io.in_ready); end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    cyc = 1;
    while (cyc < LAT + 10) begin
      @(negedge clk);
      if (io.out_valid === 1'b1) break;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== LAT) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, LAT); end
    t = int'(io.T);
    n_cmp++;
    if (!(t == exp_t || (!CORR && t == exp_t + q))) begin
      n_err++; $display("FAIL %s_T: got %0d want %0d (or +q without correction)", name, t, exp_t);
    end
    n_cmp++;
    if (io.out_tag !== tag) begin n_err++; $display("FAIL %s_tag: got %h want %h", name, io.out_tag, tag); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cs [20];
    int exp_r [20];
    int qs [20];
    int sent = 0, got = 0, it = 0, first = -1, gaps = 0, t;
    bit acc;
    for (int i = 0; i < 20; i++) begin
      cs[i]    = 16'($urandom_range(0, 37248));
      qs[i]    = (i % 2 == 0) ? 193 : 49;
      exp_r[i] = mont_ref(int'(cs[i]), qs[i]);
    end
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    while (got < 20 && it < 80) begin
      io.in_valid = (sent < 20);
      if (sent < 20) begin
        io.C = cs[sent]; io.qH = (qs[sent] == 193) ? 4'd12 : 4'd3; io.in_tag = 8'(8'h80 + sent);
      end
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      if (io.out_valid === 1'b1) begin
        if (first < 0) first = it;
        t = int'(io.T);
        n_cmp++;
        if (!(t == exp_r[got] || (!CORR && t == exp_r[got] + qs[got]))) begin
          n_err++; $display("FAIL b2b_T[%0d]: got %0d want %0d (q=%0d)", got, t, exp_r[got], qs[got]);
        end
        n_cmp++;
        if (io.out_tag !== 8'(8'h80 + got)) begin
          n_err++; $display("FAIL b2b_tag[%0d]: got %h want %h", got, io.out_tag, 8'(8'h80 + got));
        end
        got++;
      end else if (first >= 0) begin
        gaps++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      it++;
    end
    io.in_valid = 1'b0;
    n_cmp++;
    if (got !== 20) begin n_err++; $display("FAIL b2b_count: got %0d want 20", got); end
    n_cmp++;
    if (first !== LAT) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", first, LAT); end
    n_cmp++;
    if (gaps !== 0) begin n_err++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_stall();
    localparam int N = 12;
    int exp_r [N];
    int sent = 0, got = 0, it = 0, stall_n = 0, t;
    logic [8:0] prev_t;
    logic [7:0] prev_tag;
    bit acc;
    for (int i = 0; i < N; i++) exp_r[i] = mont_ref(i*3001 + 7, 193);
    @(posedge clk); #1;
    while (got < N && it < 100) begin
      io.out_ready = !(it >= LAT + 2 && it < LAT + 7);
      io.in_valid  = (sent < N);
      if (sent < N) begin
        io.C = 16'(sent*3001 + 7); io.qH = 4'd12; io.in_tag = 8'(8'h40 + sent);
      end
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      if (io.out_ready === 1'b0) begin
        n_cmp++;
        if (io.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", io.in_ready); end
        n_cmp++;
        if (io.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid: got %b want 1", io.out_valid); end
        if (stall_n > 0) begin
          n_cmp++;
          if (io.T !== prev_t || io.out_tag !== prev_tag) begin
            n_err++; $display("FAIL stall_frozen: got T=%0d tag=%h want T=%0d tag=%h", io.T, io.out_tag, prev_t, prev_tag);
          end
        end
        prev_t = io.T; prev_tag = io.out_tag;
        stall_n++;
      end else if (io.out_valid === 1'b1) begin
        t = int'(io.T);
        n_cmp++;
        if (!(t == exp_r[got] || (!CORR && t == exp_r[got] + 193))) begin
          n_err++; $display("FAIL stall_T[%0d]: got %0d want %0d", got, t, exp_r[got]);
        end
        n_cmp++;
        if (io.out_tag !== 8'(8'h40 + got)) begin
          n_err++; $display("FAIL stall_tag[%0d]: got %h want %h", got, io.out_tag, 8'(8'h40 + got));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      it++;
    end
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    n_cmp++;
    if (got !== N) begin n_err++; $display("FAIL stall_count: got %0d want %0d", got, N); end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      io.in_valid = 1'b1; io.C = 16'(k + 1); io.qH = 4'd12; io.in_tag = 8'(k);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; io.in_valid = 1'b1; io.C = 16'd1;
    @(posedge clk); #1;
    rst = 1'b0; io.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (io.out_valid !== 1'b0) begin n_err++; seen++; $display("FAIL flush_out_valid[%0d]: got %b want 0", k, io.out_valid); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (io.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", io.in_ready); end
  endtask

  initial begin
    test_reset();
    test_single(16'd1,     4'd12, 8'h11, 9, "c1");
    test_single(16'd20480, 4'd12, 8'h5A, 5, "c5x4096");
    test_single(16'd0,     4'd12, 8'hC3, 0, "c0");
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_single(16'd37248, 4'd3, 8'h77, mont_ref(37248, 49), "post_rst_q49");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
